// File: rtl/ddr_cmd_arb.sv
// DDR controller command-port arbiter: write-biased with anti-starvation for reads,
// write grants gated on controller write-FIFO fill. Optional stats via DDR_CMD_ARB_STAT_EN.
module ddr_cmd_arb #(
  parameter int ADDR_W   = 30,
  parameter int BL_W     = 6,
  parameter int WR_CNT_W = 7,
  parameter int MAX_RUN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BL_W-1:0]   wr_bl,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BL_W-1:0]   rd_bl,
  output logic              rd_ack,
  input  logic [WR_CNT_W-1:0] memc_wr_count,
  output logic              memc_cmd_req,
  output logic [2:0]        memc_cmd,
  output logic [ADDR_W-1:0] memc_cmd_addr,
  output logic [BL_W-1:0]   memc_cmd_bl,
  input  logic              memc_cmd_ack,
  output logic              busy,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_rd_cnt
);
  localparam int CW = (WR_CNT_W > BL_W) ? WR_CNT_W : BL_W;
  localparam logic [3:0] RUN_MAX = 4'(MAX_RUN);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  state_t     state;
  logic [3:0] wr_run;
  logic       owner_rd;

  logic [CW-1:0] cnt_ext, bl_ext;
  logic          wr_elig, rd_elig;

  // Write only eligible once the FIFO holds the whole burst (count >= bl+1).
  assign cnt_ext = CW'(memc_wr_count);
  assign bl_ext  = CW'(wr_bl);
  assign wr_elig = wr_req && (cnt_ext > bl_ext);
  assign rd_elig = rd_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wr_run        <= '0;
      owner_rd      <= 1'b0;
      memc_cmd_req  <= 1'b0;
      memc_cmd      <= 3'b000;
      memc_cmd_addr <= '0;
      memc_cmd_bl   <= '0;
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_elig && (!wr_elig || wr_run == RUN_MAX)) begin
            memc_cmd      <= 3'b001;
            memc_cmd_addr <= rd_addr;
            memc_cmd_bl   <= rd_bl;
            memc_cmd_req  <= 1'b1;
            owner_rd      <= 1'b1;
            wr_run        <= '0;
            busy          <= 1'b1;
            state         <= ISSUE;
          end else if (wr_elig) begin
            memc_cmd      <= 3'b000;
            memc_cmd_addr <= wr_addr;
            memc_cmd_bl   <= wr_bl;
            memc_cmd_req  <= 1'b1;
            owner_rd      <= 1'b0;
            wr_run        <= (wr_run == RUN_MAX) ? wr_run : wr_run + 4'd1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (memc_cmd_ack) begin
            memc_cmd_req <= 1'b0;
            wr_ack       <= !owner_rd;
            rd_ack       <= owner_rd;
            state        <= GAP;
          end
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDR_CMD_ARB_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else begin
      if (wr_ack) stat_wr_cnt <= stat_wr_cnt + 16'd1;
      if (rd_ack) stat_rd_cnt <= stat_rd_cnt + 16'd1;
    end
  end
`else
  assign stat_wr_cnt = '0;
  assign stat_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr_cmd_arb.sv
// Directed bench for ddr_cmd_arb: inputs driven and outputs sampled 1 time unit after posedge.
module tb_ddr_cmd_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req, wr_ack, rd_ack;
  logic [29:0] wr_addr, rd_addr, memc_cmd_addr;
  logic [5:0]  wr_bl, rd_bl, memc_cmd_bl;
  logic [6:0]  memc_wr_count;
  logic        memc_cmd_req, memc_cmd_ack, busy;
  logic [2:0]  memc_cmd;
  logic [15:0] stat_wr_cnt, stat_rd_cnt;

  int errors = 0;
  int checks = 0;

  ddr_cmd_arb dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_bl(wr_bl), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_bl(rd_bl), .rd_ack(rd_ack),
    .memc_wr_count(memc_wr_count),
    .memc_cmd_req(memc_cmd_req), .memc_cmd(memc_cmd),
    .memc_cmd_addr(memc_cmd_addr), .memc_cmd_bl(memc_cmd_bl),
    .memc_cmd_ack(memc_cmd_ack), .busy(busy),
    .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; memc_cmd_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; memc_cmd_ack = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_bl = '0; rd_bl = '0; memc_wr_count = '0;
    #1;
    checks++;
    if ({memc_cmd_req, memc_cmd, wr_ack, rd_ack, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl got %b want 0", {memc_cmd_req, memc_cmd, wr_ack, rd_ack, busy});
    end
    checks++;
    if ({memc_cmd_addr, memc_cmd_bl} !== 36'b0) begin
      errors++; $display("FAIL reset_fields got %h want 0", {memc_cmd_addr, memc_cmd_bl});
    end
    checks++;
    if ({stat_wr_cnt, stat_rd_cnt} !== 32'b0) begin
      errors++; $display("FAIL reset_stats got %h want 0", {stat_wr_cnt, stat_rd_cnt});
    end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    wr_addr = 30'h100; wr_bl = 6'd3; memc_wr_count = 7'd4; wr_req = 1'b1;
    tick();
    checks++;
    if ({memc_cmd_req, memc_cmd, memc_cmd_addr, memc_cmd_bl, busy} !== {1'b1, 3'b000, 30'h100, 6'd3, 1'b1}) begin
      errors++; $display("FAIL wr_issue got req=%b cmd=%b addr=%h bl=%0d busy=%b want 1 000 100 3 1",
        memc_cmd_req, memc_cmd, memc_cmd_addr, memc_cmd_bl, busy);
    end
    wr_addr = 30'h3FF; wr_bl = 6'd9;   // must be ignored while issuing
    tick();
    checks++;
    if ({memc_cmd_req, memc_cmd, memc_cmd_addr, memc_cmd_bl, wr_ack} !== {1'b1, 3'b000, 30'h100, 6'd3, 1'b0}) begin
      errors++; $display("FAIL wr_hold got req=%b cmd=%b addr=%h bl=%0d ack=%b want 1 000 100 3 0",
        memc_cmd_req, memc_cmd, memc_cmd_addr, memc_cmd_bl, wr_ack);
    end
    memc_cmd_ack = 1'b1;
    tick();
    checks++;
    if ({memc_cmd_req, wr_ack, rd_ack, busy} !== 4'b0101) begin
      errors++; $display("FAIL wr_gap got req/wack/rack/busy=%b want 0101", {memc_cmd_req, wr_ack, rd_ack, busy});
    end
    memc_cmd_ack = 1'b0; wr_req = 1'b0;
    tick();
    checks++;
    if ({memc_cmd_req, wr_ack, rd_ack, busy} !== 4'b0000) begin
      errors++; $display("FAIL wr_idle got req/wack/rack/busy=%b want 0000", {memc_cmd_req, wr_ack, rd_ack, busy});
    end
  endtask

  task automatic test_gating();
    int bad = 0;
    wr_bl = 6'd7; memc_wr_count = 7'd5; wr_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (memc_cmd_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL gate_low req high in %0d of 20 cycles want 0", bad);
    end
    memc_wr_count = 7'd7;   // count == bl: still one word short
    tick(); tick();
    checks++;
    if (memc_cmd_req !== 1'b0) begin
      errors++; $display("FAIL gate_edge got req=%b want 0", memc_cmd_req);
    end
    memc_wr_count = 7'd8;
    tick();
    checks++;
    if ({memc_cmd_req, memc_cmd_bl} !== {1'b1, 6'd7}) begin
      errors++; $display("FAIL gate_open got req=%b bl=%0d want 1 7", memc_cmd_req, memc_cmd_bl);
    end
    memc_cmd_ack = 1'b1;
    tick();
    memc_cmd_ack = 1'b0; wr_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic [9:0] exp_rd = 10'b10_0001_0000;
    logic [9:0] got_rd = '0;
    int n = 0;
    int both = 0;
    do_reset();
    wr_bl = 6'd0; rd_bl = 6'd0; wr_addr = 30'h10; rd_addr = 30'h20;
    memc_wr_count = 7'd127; wr_req = 1'b1; rd_req = 1'b1; memc_cmd_ack = 1'b1;
    for (int c = 0; c < 40 && n < 10; c++) begin
      tick();
      if (wr_ack && rd_ack) both++;
      if (rd_ack) begin got_rd[n] = 1'b1; n++; end
      else if (wr_ack) n++;
    end
    wr_req = 1'b0; rd_req = 1'b0; memc_cmd_ack = 1'b0;
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL cont_count got %0d grants want 10", n);
    end
    checks++;
    if (both != 0) begin
      errors++; $display("FAIL cont_both got %0d dual-ack cycles want 0", both);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got_rd[i] !== exp_rd[i]) begin
        errors++; $display("FAIL cont_grant%0d got %s want %s", i, got_rd[i] ? "R" : "W", exp_rd[i] ? "R" : "W");
      end
    end
    tick(); tick(); tick();
  endtask

  task automatic test_slow_read();
    int bad = 0;
    rd_addr = 30'h2AAAAAAA; rd_bl = 6'd15; rd_req = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      if ({memc_cmd_req, memc_cmd, memc_cmd_addr, memc_cmd_bl, rd_ack} !== {1'b1, 3'b001, 30'h2AAAAAAA, 6'd15, 1'b0}) bad++;
      if (i == 4) begin rd_addr = 30'h1; rd_bl = 6'd2; end
      if (i == 9) memc_cmd_ack = 1'b1;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL slow_hold %0d of 10 cycles wrong want req=1 cmd=001 stable", bad);
    end
    checks++;
    if ({memc_cmd_req, rd_ack, wr_ack} !== 3'b010) begin
      errors++; $display("FAIL slow_ack got req/rack/wack=%b want 010", {memc_cmd_req, rd_ack, wr_ack});
    end
    memc_cmd_ack = 1'b0; rd_req = 1'b0;
    tick();
    checks++;
    if (rd_ack !== 1'b0) begin
      errors++; $display("FAIL slow_single got rd_ack=%b want 0", rd_ack);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    wr_addr = 30'h44; wr_bl = 6'd1; memc_wr_count = 7'd10; wr_req = 1'b1;
    tick();
    checks++;
    if (memc_cmd_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got req=%b want 1", memc_cmd_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({memc_cmd_req, busy, memc_cmd_addr} !== {1'b0, 1'b0, 30'h0}) begin
      errors++; $display("FAIL rstmid_async got req=%b busy=%b addr=%h want 0 0 0", memc_cmd_req, busy, memc_cmd_addr);
    end
    wr_req = 1'b0; memc_cmd_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wr_ack || rd_ack) acks++;
    end
    rst = 1'b0; memc_cmd_ack = 1'b0;
    rd_addr = 30'h77; rd_bl = 6'd4; rd_req = 1'b1;
    tick();
    checks++;
    if ({memc_cmd_req, memc_cmd, memc_cmd_addr} !== {1'b1, 3'b001, 30'h77}) begin
      errors++; $display("FAIL rstmid_read got req=%b cmd=%b addr=%h want 1 001 77", memc_cmd_req, memc_cmd, memc_cmd_addr);
    end
    memc_cmd_ack = 1'b1;
    tick();
    if (wr_ack) acks++;
    checks++;
    if (rd_ack !== 1'b1) begin
      errors++; $display("FAIL rstmid_rdack got %b want 1", rd_ack);
    end
    memc_cmd_ack = 1'b0; rd_req = 1'b0;
    tick(); tick();
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL rstmid_noack got %0d stray acks want 0", acks);
    end
  endtask

  task automatic do_cmd(input logic is_rd);
    rd_req = is_rd; wr_req = !is_rd;
    tick();
    memc_cmd_ack = 1'b1;
    tick();
    memc_cmd_ack = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    tick();
  endtask

  task automatic test_stats();
    logic [15:0] exp_w, exp_r;
`ifdef DDR_CMD_ARB_STAT_EN
    exp_w = 16'd3; exp_r = 16'd2;
`else
    exp_w = 16'd0; exp_r = 16'd0;
`endif
    do_reset();
    wr_bl = 6'd0; memc_wr_count = 7'd1; rd_bl = 6'd0;
    do_cmd(1'b0); do_cmd(1'b0); do_cmd(1'b0);
    do_cmd(1'b1); do_cmd(1'b1);
    tick();
    checks++;
    if (stat_wr_cnt !== exp_w) begin
      errors++; $display("FAIL stat_wr got %0d want %0d", stat_wr_cnt, exp_w);
    end
    checks++;
    if (stat_rd_cnt !== exp_r) begin
      errors++; $display("FAIL stat_rd got %0d want %0d", stat_rd_cnt, exp_r);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_gating();
    test_contention();
    test_slow_read();
    test_reset_mid();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
